// File: rtl/pdm_seq_pkg.sv
// Shared definitions for the pdm ramp sequencer: scan FSM states,
// register-map offsets and STATUS bit positions.
package pdm_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fsm_t;

    // Per-channel register pair: word 2*i is TARGET, word 2*i+1 is STEP.
    localparam int OFS_TARGET = 0;
    localparam int OFS_STEP   = 1;

    // STATUS register bits.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVERRUN = 1;

    // STATUS sits right after the last channel's register pair.
    function automatic int status_index(input int channels);
        return 2 * channels;
    endfunction

endpackage

// File: rtl/pdm_ramp_step.sv
// Ramp step: moves a level one step toward its target without overshoot.
// A zero step means "jump straight to the target".
module pdm_ramp_step #(
    parameter int pBits = 8
) (
    input  logic [pBits-1:0] cur,
    input  logic [pBits-1:0] target,
    input  logic [pBits-1:0] step,
    output logic [pBits-1:0] nxt
);

    // Next level: clamp to target whenever the remaining distance fits in one step.
    always_comb begin
        // NOTE: nxt gets a default before any branch so no path leaves it unassigned (no latch).
        nxt = cur;
        if (step == '0) begin
            nxt = target;
        end else if (cur < target) begin
            nxt = (target - cur <= step) ? target : cur + step;
        end else if (cur > target) begin
            nxt = (cur - target <= step) ? target : cur - step;
        end
    end

endmodule

// File: rtl/pdm_ramp_sequencer.sv
// Wishbone peripheral that ramps a bank of pdm channel levels toward
// programmed targets. Each prescaler tick launches one scan pass that
// visits channels in order, one per clock, and loads changed levels into
// the channel array through a one-hot strobe and a shared data bus.
module pdm_ramp_sequencer
    import pdm_seq_pkg::*;
#(
    parameter int pBits     = 8,
    parameter int pChannels = 4,
    parameter int pPrescale = 1000,
    localparam int AW       = $clog2(2 * pChannels + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_adr,
    input  logic [31:0]          wb_dat_c,
    output logic [31:0]          wb_dat_p,
    output logic                 wb_ack,
    output logic [pChannels-1:0] chan_stb,
    output logic [pBits-1:0]     chan_data
);

    localparam int PW         = $clog2(pPrescale);
    localparam int IW         = (pChannels > 1) ? $clog2(pChannels) : 1;
    localparam int STATUS_ADR = status_index(pChannels);

    if (pChannels < 1) begin : g_bad_channels
        $error("pdm_ramp_sequencer: pChannels must be >= 1");
    end
    if (pPrescale < pChannels + 1) begin : g_bad_prescale
        $error("pdm_ramp_sequencer: pPrescale must be >= pChannels+1");
    end

    logic [pBits-1:0] cur    [pChannels];
    logic [pBits-1:0] target [pChannels];
    logic [pBits-1:0] step   [pChannels];

    logic [PW-1:0] pre_cnt;
    logic          pre_wrap;
    logic          tick;

    fsm_t          state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          overrun, overrun_set;
    logic          visit;

    logic [pBits-1:0] vis_cur, vis_nxt;

    logic          adr_is_chan, adr_is_status;
    logic [IW-1:0] adr_ch;
    logic          wr_chan, wr_status;
    logic [31:0]   rdata;

    // Upper write-data bits beyond the level width carry no meaning.
    if (pBits < 32) begin : g_unused_dat
        logic unused_dat;
        assign unused_dat = ^wb_dat_c[31:pBits];
    end

    // Bus decode.
    assign adr_is_chan   = (wb_adr < AW'(2 * pChannels));
    assign adr_is_status = (wb_adr == AW'(STATUS_ADR));
    assign adr_ch        = wb_adr[IW:1];
    assign wr_chan       = wb_stb && wb_we && adr_is_chan;
    assign wr_status     = wb_stb && wb_we && adr_is_status;

    // Prescaler wrap and scan trigger; the counter wraps on its own compare
    // so the count never depends on the trigger net.
    assign pre_wrap = (pre_cnt == PW'(pPrescale - 1));
    assign tick     = pre_wrap;

    // Free-running prescaler, 0..pPrescale-1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_wrap) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Scan FSM next state: one channel per clock, ticks during a pass are dropped.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                overrun_set = tick;
                if (idx == IW'(pChannels - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign visit   = (state == SCAN);
    assign vis_cur = cur[idx];

    // The single ramp stepper is shared by all channels through idx.
    pdm_ramp_step #(
        .pBits(pBits)
    ) u_step (
        .cur   (vis_cur),
        .target(target[idx]),
        .step  (step[idx]),
        .nxt   (vis_nxt)
    );

    // Channel register file: visit updates cur, bus writes update target/step.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these arrays are small flop banks, not RAM, so clearing them all on reset is intended.
            for (int i = 0; i < pChannels; i++) begin
                cur[i]    <= '0;
                target[i] <= '0;
                step[i]   <= '0;
            end
        end else begin
            if (visit) begin
                cur[idx] <= vis_nxt;
            end
            if (wr_chan) begin
                if (wb_adr[0] == 1'(OFS_STEP)) begin
                    step[adr_ch] <= wb_dat_c[pBits-1:0];
                end else begin
                    target[adr_ch] <= wb_dat_c[pBits-1:0];
                end
            end
        end
    end

    // Level-load strobe for the channel array, one cycle after its visit.
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_stb  <= '0;
            chan_data <= '0;
        end else if (visit && (vis_nxt != vis_cur)) begin
            chan_stb  <= pChannels'(1) << idx;
            chan_data <= vis_nxt;
        end else begin
            chan_stb  <= '0;
            chan_data <= '0;
        end
    end

    // Overrun flag: set by a dropped tick, cleared by writing 1 to its bit; set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (wr_status && wb_dat_c[STAT_OVERRUN]) begin
            overrun <= 1'b0;
        end
    end

    // Read mux; TARGET words return the live level, not the target.
    always_comb begin
        rdata = '0;
        if (adr_is_chan) begin
            if (wb_adr[0] == 1'(OFS_STEP)) begin
                rdata[pBits-1:0] = step[adr_ch];
            end else begin
                rdata[pBits-1:0] = cur[adr_ch];
            end
        end else if (adr_is_status) begin
            rdata[STAT_BUSY]    = visit;
            rdata[STAT_OVERRUN] = overrun;
        end
    end

    // Registered Wishbone response: ack and read data one cycle after stb.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_dat_p <= '0;
        end else begin
            wb_ack   <= wb_stb;
            wb_dat_p <= (wb_stb && !wb_we) ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_pdm_ramp_sequencer.sv
// Self-checking bench for pdm_ramp_sequencer. A cycle-level behavioural
// model derives every expected output from the register map, the tick
// schedule and the step rule; directed scenarios pin literal values.
module tb_pdm_ramp_sequencer;

    localparam int BITS = 8;
    localparam int CH   = 4;
    localparam int PRE  = 16;
    localparam int AW   = 4;

    typedef struct {
        int         cyc;
        logic [3:0] stb;
        logic [7:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_stb = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_adr = '0;
    logic [31:0]   wb_dat_c = '0;
    logic [31:0]   wb_dat_p;
    logic          wb_ack;
    logic [CH-1:0] chan_stb;
    logic [BITS-1:0] chan_data;

    bit force_tick = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    pdm_ramp_sequencer #(
        .pBits(BITS),
        .pChannels(CH),
        .pPrescale(PRE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_c (wb_dat_c),
        .wb_dat_p (wb_dat_p),
        .wb_ack   (wb_ack),
        .chan_stb (chan_stb),
        .chan_data(chan_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_cur [CH];
    int   m_tgt [CH];
    int   m_step[CH];
    bit   m_over = 1'b0;
    int   m_pc = 0;
    int   m_cyc = 0;
    int   m_tick_at = -1000;
    int   m_visit_now = -1;
    bit   m_valid = 1'b0;
    logic        e_ack = 1'b0;
    logic [31:0] e_dat_p = '0;
    logic [3:0]  e_stb = '0;
    logic [7:0]  e_data = '0;

    ent_t log_q[$];
    int   exp_q[$];

    // Distance-based step rule in plain integers.
    function automatic int ramp_model(input int c, input int t, input int s);
        int d;
        d = t - c;
        if (s == 0 || (d <= s && d >= -s)) return t;
        return (d > 0) ? c + s : c - s;
    endfunction

    always @(posedge clk) begin
        int a;
        int ch;
        int nxt;
        int v;
        logic [31:0] rd;
        logic busy;
        logic tk;
        a = int'(wb_adr);
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_cur[i]  = 0;
                m_tgt[i]  = 0;
                m_step[i] = 0;
            end
            m_over    = 1'b0;
            m_pc      = 0;
            m_tick_at = -1000;
            e_ack     = 1'b0;
            e_dat_p   = '0;
            e_stb     = '0;
            e_data    = '0;
            m_valid   = 1'b1;
        end else begin
            tk   = (m_pc == PRE - 1) || force_tick;
            busy = (m_visit_now >= 0);
            rd   = '0;
            if (wb_stb && !wb_we) begin
                if (a < 2 * CH) rd = 32'((a % 2 == 1) ? m_step[a / 2] : m_cur[a / 2]);
                else if (a == 2 * CH) rd = {30'd0, m_over, busy};
            end
            e_ack   = wb_stb;
            e_dat_p = rd;
            e_stb   = '0;
            e_data  = '0;
            if (busy) begin
                ch  = m_visit_now;
                nxt = ramp_model(m_cur[ch], m_tgt[ch], m_step[ch]);
                if (nxt != m_cur[ch]) begin
                    e_stb  = 4'(1 << ch);
                    e_data = 8'(nxt);
                end
                m_cur[ch] = nxt;
            end
            if (wb_stb && wb_we) begin
                if (a < 2 * CH) begin
                    if (a % 2 == 1) m_step[a / 2] = int'(wb_dat_c[7:0]);
                    else m_tgt[a / 2] = int'(wb_dat_c[7:0]);
                end else if (a == 2 * CH && wb_dat_c[1]) begin
                    m_over = 1'b0;
                end
            end
            if (tk && busy) m_over = 1'b1;
            if (tk && !busy) m_tick_at = m_cyc;
            m_pc = (m_pc + 1) % PRE;
        end
        m_cyc++;
        v = m_cyc - m_tick_at - 1;
        m_visit_now = (v >= 0 && v < CH) ? v : -1;
    end

    // Compare every cycle, away from the active edge; log all strobes.
    always @(negedge clk) begin
        if (m_valid) begin
            check("wb_ack", 32'(wb_ack), 32'(e_ack));
            check("wb_dat_p", wb_dat_p, e_dat_p);
            check("chan_stb", 32'(chan_stb), 32'(e_stb));
            check("chan_data", 32'(chan_data), 32'(e_data));
            if (chan_stb != '0) log_q.push_back('{m_cyc, chan_stb, chan_data});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input int adr, input logic [31:0] d);
        wb_stb   = 1'b1;
        wb_we    = 1'b1;
        wb_adr   = 4'(adr);
        wb_dat_c = d;
        @(negedge clk);
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic bus_read(input int adr, output logic [31:0] d);
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = 4'(adr);
        @(negedge clk);
        d      = wb_dat_p;
        wb_stb = 1'b0;
    endtask

    task automatic wait_visit(input int ch);
        for (int k = 0; k < 64 && m_visit_now != ch; k++) @(negedge clk);
        check($sformatf("visit%0d_reached", ch), 32'(m_visit_now == ch), 32'd1);
    endtask

    task automatic wait_pc(input int pc);
        for (int k = 0; k < 64 && m_pc != pc; k++) @(negedge clk);
        check("prescale_phase_reached", 32'(m_pc == pc), 32'd1);
    endtask

    // Strobes logged for one channel must match exp_q in order and count.
    task automatic expect_seq(input string name, input logic [3:0] mask);
        int k;
        k = 0;
        foreach (log_q[j]) begin
            if (log_q[j].stb == mask) begin
                if (k < exp_q.size())
                    check($sformatf("%s[%0d]", name, k), 32'(log_q[j].data), 32'(exp_q[k]));
                k++;
            end
        end
        check({name, "_count"}, 32'(k), 32'(exp_q.size()));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;

        // Reset held two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_chan_stb", 32'(chan_stb), 32'd0);
        check("rst_chan_data", 32'(chan_data), 32'd0);
        check("rst_wb_ack", 32'(wb_ack), 32'd0);
        bus_read(2 * CH, rd);
        check("rst_status", rd, 32'd0);
        bus_read(0, rd);
        check("rst_target0", rd, 32'd0);

        // Ramp up channel 0.
        bus_write(1, 32'h40);
        bus_write(0, 32'hA0);
        log_q.delete();
        repeat (5 * PRE) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'hA0);
        expect_seq("ramp_up", 4'b0001);
        check("ramp_up_total", 32'(log_q.size()), 32'd3);
        bus_read(0, rd);
        check("ramp_up_level", rd, 32'hA0);

        // Ramp down with clamping at the target.
        bus_write(1, 32'h30);
        bus_write(0, 32'hFFFF_FF05);
        log_q.delete();
        repeat (6 * PRE) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'h70);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h05);
        expect_seq("ramp_down", 4'b0001);
        check("ramp_down_total", 32'(log_q.size()), 32'd4);

        // Immediate jumps on channels 1 and 3 within a single pass.
        wait_pc(1);
        bus_write(3, 32'h0);
        bus_write(7, 32'h0);
        bus_write(2, 32'h11);
        bus_write(6, 32'h33);
        log_q.delete();
        repeat (PRE + 4) @(negedge clk);
        check("jump_total", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("jump_stb_a", 32'(log_q[0].stb), 32'b0010);
            check("jump_data_a", 32'(log_q[0].data), 32'h11);
            check("jump_stb_b", 32'(log_q[1].stb), 32'b1000);
            check("jump_data_b", 32'(log_q[1].data), 32'h33);
            check("jump_spacing", 32'(log_q[1].cyc - log_q[0].cyc), 32'd2);
        end

        // Target write in the same cycle channel 2 is visited.
        bus_write(5, 32'h10);
        bus_write(4, 32'h80);
        log_q.delete();
        for (int k = 0; k < 3 * PRE && log_q.size() == 0; k++) @(negedge clk);
        check("coll_first_stb", 32'(log_q.size() > 0 ? log_q[0].data : 8'h00), 32'h10);
        wait_visit(2);
        log_q.delete();
        bus_write(4, 32'h00);
        repeat (4 * PRE) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h00);
        expect_seq("collision", 4'b0100);

        // Tick forced while scanning raises overrun; writing bit1 clears it.
        wait_visit(1);
        force dut.tick = 1'b1;
        force_tick = 1'b1;
        @(negedge clk);
        release dut.tick;
        force_tick = 1'b0;
        bus_read(2 * CH, rd);
        check("overrun_set", 32'(rd[1]), 32'd1);
        bus_write(2 * CH, 32'h0);
        bus_read(2 * CH, rd);
        check("overrun_hold_on_zero", 32'(rd[1]), 32'd1);
        bus_write(2 * CH, 32'h2);
        bus_read(2 * CH, rd);
        check("overrun_cleared", 32'(rd[1]), 32'd0);

        // Reset mid-pass aborts the scan.
        bus_write(7, 32'h08);
        bus_write(6, 32'hF0);
        wait_visit(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        repeat (40) @(negedge clk);
        check("rst_abort_no_stb", 32'(log_q.size()), 32'd0);
        bus_read(2 * CH, rd);
        check("rst_abort_status", rd, 32'd0);

        // Randomised bus traffic, including out-of-map addresses and rare resets.
        for (int n = 0; n < 900; n++) begin
            rst    = ($urandom_range(0, 299) == 0);
            wb_stb = 1'($urandom);
            wb_we  = 1'($urandom);
            wb_adr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                 : 4'($urandom_range(0, 8));
            wb_dat_c = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            @(negedge clk);
        end
        rst    = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        repeat (3 * PRE) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
